spc700_alu_seq: RTL and testbench
=================================

// Module: spc700_alu_seq
// PURPOSE
//  Parametrised sequential ALU; next generation of the SPC700 datapath ALU. Adds WIDTH
//  generalisation, an integrated iterative MUL/DIV engine and a START/BUSY/DONE handshake.
//  Sits between the SPC700 decoder/sequencer and the register file. Results and flags are registered.
// PARAMETERS
//  W      8   operand width in bits; even, >=4
// PORTS
//  CLK    in   1   clock
//  RST_N  in   1   async active-low reset
//  EN     in   1   clock enable; 0 freezes all state, including DONE and the iteration counter
//  START  in   1   op request; sampled only in IDLE with EN=1
//  OP     in   5   opcode, see BEHAVIOUR
//  L      in   W   left operand / dividend low half
//  LH     in   W   dividend high half (DIV only)
//  R      in   W   right operand / divisor
//  CI,HI,VI,ZI in 1  incoming C/H/V/Z flags
//  W16    in   1   16-bit chaining: ZO = ZI & zero(result)
//  BUSY   out  1   multi-cycle op in progress
//  DONE   out  1   one-cycle pulse: RES/RES_HI/flags valid
//  RES    out  W   result / MUL low half / DIV quotient
//  RES_HI out  W   MUL high half / DIV remainder; 0 for other ops
//  CO,VO,HO,SO,ZO out 1  result flags
// BEHAVIOUR
//  Reset (async): state=IDLE; BUSY, DONE, RES, RES_HI and all flags = 0.
//  OP codes: 00 OR, 01 AND, 02 XOR, 03 MOV(R), 04 ADC, 05 SBC (L-R-!CI), 06 ADD (CI=0),
//   07 SUB (CI=1), 08 ASL, 09 ROL, 0A LSR, 0B ROR (shifts act on R, C=bit out),
//   0C XCN (swap W/2 halves of R), 0D MUL, 0E DIV, 10 DAA, 11 DAS (see CONFIGURATION).
//   Any other code is reserved: RES=L, flags pass through, DONE still pulses.
//  Flags: SO = MSB of result; ZO = zero(result), ANDed with ZI when W16=1.
//   ADC/SBC/ADD/SUB update C, V and H (H = carry/borrow out of bit 3).
//   Shifts update C only. Logic ops, MOV and XCN pass C/V/H through.
//  FSM states: IDLE, MUL, DIV.
//  Single-cycle op: START accepted at edge k; results and DONE=1 valid after edge k; DONE drops after edge k+1.
//  MUL (unsigned): accepted at edge k -> BUSY=1. Shift-add steps at edges k+1..k+W.
//   At edge k+W: BUSY=0, DONE=1, {RES_HI,RES} = L*R. SO/ZO taken from RES_HI. C/V/H unchanged.
//  DIV (unsigned): dividend {LH,L}, divisor R.
//   Overflow (LH >= R, which includes R=0): no iterations. After edge k: RES = all ones,
//    RES_HI = LH, VO=1, DONE=1.
//   Otherwise restoring division, steps at edges k+1..k+W. Then RES = quotient,
//    RES_HI = remainder, VO=0.
//   HO = (LH[3:0] >= R[3:0]). SO/ZO taken from RES.
//  START while BUSY=1 is ignored and not queued. START in the DONE cycle is accepted
//   (back-to-back ops allowed).
//  Operands are latched at accept; input changes during BUSY have no effect.
//  Reset mid-operation aborts to IDLE with every output = 0; no DONE is issued.
//  EN=0 during BUSY stretches latency by exactly the number of disabled cycles.
// CONFIGURATION
//  SPC700_ALU_BCD_EN defined: OP 10 = DAA, OP 11 = DAS, applied to L with CI/HI.
//   Requires W=8 (elaboration error otherwise). Adjust +/-0x60 if C or L>0x99; +/-0x06 if H or L[3:0]>9.
//   C is updated; H passes through; single-cycle.
//  Not defined: OP 10/11 are reserved (RES=L, flags pass through); no BCD logic is synthesised.
// TESTING (W=8)
//  ADC L=0x7F R=0x01 CI=0 -> RES=0x80, VO=1, SO=1, HO=1, CO=0, DONE one cycle after accept.
//  MUL L=0xFF R=0xFF -> BUSY for 8 cycles; RES_HI=0xFE, RES=0x01, SO=1, ZO=0.
//  DIV LH=0x01 L=0x00 R=0x10 -> RES=0x10, RES_HI=0x00, VO=0. Same with R=0x00 -> RES=0xFF, VO=1, 1-cycle.
//  START pulsed during MUL is ignored; RST_N low mid-DIV -> BUSY=0, DONE never asserts.
//  EN low 3 cycles during MUL -> DONE at accept+11; W16=1, ZI=0, SUB 5-5 -> ZO=0.
//  BCD_EN: DAA L=0x9A CI=0 HI=0 -> RES=0x00, CO=1; without macro -> RES=0x9A.

Source files
------------

// File: rtl/spc700_alu_seq.sv
// Sequential SPC700 ALU: registered single-cycle ops plus an iterative MUL/DIV engine behind a START/BUSY/DONE handshake.
// Optional BCD adjust (DAA/DAS on OP 10/11) is built only when SPC700_ALU_BCD_EN is defined; it requires W=8.
module spc700_alu_seq #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_start,
    input  logic [4:0]   i_op,
    input  logic [W-1:0] i_l,
    input  logic [W-1:0] i_lh,
    input  logic [W-1:0] i_r,
    input  logic         i_ci,
    input  logic         i_hi,
    input  logic         i_vi,
    input  logic         i_zi,
    input  logic         i_w16,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_res,
    output logic [W-1:0] o_res_hi,
    output logic         o_co,
    output logic         o_vo,
    output logic         o_ho,
    output logic         o_so,
    output logic         o_zo
);
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [4:0] OP_OR  = 5'h00;
    localparam logic [4:0] OP_AND = 5'h01;
    localparam logic [4:0] OP_XOR = 5'h02;
    localparam logic [4:0] OP_MOV = 5'h03;
    localparam logic [4:0] OP_ADC = 5'h04;
    localparam logic [4:0] OP_SBC = 5'h05;
    localparam logic [4:0] OP_ADD = 5'h06;
    localparam logic [4:0] OP_SUB = 5'h07;
    localparam logic [4:0] OP_ASL = 5'h08;
    localparam logic [4:0] OP_ROL = 5'h09;
    localparam logic [4:0] OP_LSR = 5'h0A;
    localparam logic [4:0] OP_ROR = 5'h0B;
    localparam logic [4:0] OP_XCN = 5'h0C;
    localparam logic [4:0] OP_MUL = 5'h0D;
    localparam logic [4:0] OP_DIV = 5'h0E;
`ifdef SPC700_ALU_BCD_EN
    localparam logic [4:0] OP_DAA = 5'h10;
    localparam logic [4:0] OP_DAS = 5'h11;
`endif

    if ((W < 4) || (W % 2 != 0)) begin : g_bad_width
        $error("spc700_alu_seq: W must be even and >= 4");
    end
`ifdef SPC700_ALU_BCD_EN
    if (W != 8) begin : g_bad_bcd_width
        $error("spc700_alu_seq: BCD adjust requires W = 8");
    end
`endif

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_a;      // multiplicand / divisor
    logic [W-1:0]  r_hi;     // product high half / partial remainder
    logic [W-1:0]  r_lo;     // multiplier / quotient, shifted one bit per step
    logic          r_ci;
    logic          r_vi;
    logic          r_hf;
    logic          r_zi;
    logic          r_w16;

    function automatic logic zero_flag(input logic [W-1:0] v, input logic w16, input logic zi);
        return (v == '0) && (!w16 || zi);
    endfunction

    // Single-cycle datapath. Subtraction is addition of ~R, so C and H read as "no borrow".
    logic [W-1:0] w_rop;
    logic         w_cin;
    logic [W:0]   w_sum;
    logic         w_hc;
    logic [W-1:0] w_res;
    logic         w_c;
    logic         w_v;
    logic         w_h;
`ifdef SPC700_ALU_BCD_EN
    logic         w_bcd_hi;
    logic         w_bcd_lo;
`endif

    always_comb begin
        w_rop = ((i_op == OP_SBC) || (i_op == OP_SUB)) ? ~i_r : i_r;
        case (i_op)
            OP_ADD:  w_cin = 1'b0;
            OP_SUB:  w_cin = 1'b1;
            default: w_cin = i_ci;
        endcase
        w_sum = {1'b0, i_l} + {1'b0, w_rop} + {{W{1'b0}}, w_cin};
    end

    if (W > 4) begin : g_hc_wide
        assign w_hc = w_sum[4] ^ i_l[4] ^ w_rop[4];
    end else begin : g_hc_narrow
        assign w_hc = w_sum[4];
    end

    always_comb begin
        w_res = i_l;
        w_c   = i_ci;
        w_v   = i_vi;
        w_h   = i_hi;
`ifdef SPC700_ALU_BCD_EN
        w_bcd_hi = i_ci || (i_l > W'('h99));
        w_bcd_lo = i_hi || (i_l[3:0] > 4'd9);
`endif
        case (i_op)
            OP_OR:  w_res = i_l | i_r;
            OP_AND: w_res = i_l & i_r;
            OP_XOR: w_res = i_l ^ i_r;
            OP_MOV: w_res = i_r;
            OP_ADC, OP_SBC, OP_ADD, OP_SUB: begin
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_h   = w_hc;
                w_v   = (i_l[W-1] == w_rop[W-1]) && (w_sum[W-1] != i_l[W-1]);
            end
            OP_ASL: begin w_res = {i_r[W-2:0], 1'b0}; w_c = i_r[W-1]; end
            OP_ROL: begin w_res = {i_r[W-2:0], i_ci}; w_c = i_r[W-1]; end
            OP_LSR: begin w_res = {1'b0, i_r[W-1:1]}; w_c = i_r[0];   end
            OP_ROR: begin w_res = {i_ci, i_r[W-1:1]}; w_c = i_r[0];   end
            OP_XCN: w_res = {i_r[W/2-1:0], i_r[W-1:W/2]};
`ifdef SPC700_ALU_BCD_EN
            OP_DAA: begin
                w_res = i_l + (w_bcd_hi ? W'('h60) : '0) + (w_bcd_lo ? W'('h06) : '0);
                w_c   = w_bcd_hi;
            end
            OP_DAS: begin
                w_res = i_l - (w_bcd_hi ? W'('h60) : '0) - (w_bcd_lo ? W'('h06) : '0);
                w_c   = w_bcd_hi;
            end
`endif
            default: ;
        endcase
    end

    // One shift-add multiply step and one restoring-divide step.
    logic [W:0]     w_madd;
    logic [2*W-1:0] w_mprod;
    logic [W:0]     w_dt;
    logic [W:0]     w_ddiff;
    logic           w_dge;
    logic [W-1:0]   w_rem_n;
    logic [W-1:0]   w_quo_n;
    logic           w_last;

    always_comb begin
        w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_mprod = {w_madd, r_lo[W-1:1]};
        w_dt    = {r_hi, r_lo[W-1]};
        w_ddiff = w_dt - {1'b0, r_a};
        w_dge   = !w_ddiff[W];
        w_rem_n = w_dge ? w_ddiff[W-1:0] : w_dt[W-1:0];
        w_quo_n = {r_lo[W-2:0], w_dge};
        w_last  = (r_cnt == CW'(W - 1));
    end

    // NOTE: every register, including the operand latches, is reset so a mid-operation reset leaves no stale state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_ci     <= 1'b0;
            r_vi     <= 1'b0;
            r_hf     <= 1'b0;
            r_zi     <= 1'b0;
            r_w16    <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_res    <= '0;
            o_res_hi <= '0;
            o_co     <= 1'b0;
            o_vo     <= 1'b0;
            o_ho     <= 1'b0;
            o_so     <= 1'b0;
            o_zo     <= 1'b0;
        end else if (i_en) begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_cnt <= '0;
                    r_ci  <= i_ci;
                    r_vi  <= i_vi;
                    r_zi  <= i_zi;
                    r_w16 <= i_w16;
                    if (i_op == OP_MUL) begin
                        r_a     <= i_l;
                        r_hi    <= '0;
                        r_lo    <= i_r;
                        r_hf    <= i_hi;
                        r_state <= S_MUL;
                        o_busy  <= 1'b1;
                    end else if (i_op == OP_DIV && i_lh < i_r) begin
                        r_a     <= i_r;
                        r_hi    <= i_lh;
                        r_lo    <= i_l;
                        r_hf    <= (i_lh[3:0] >= i_r[3:0]);
                        r_state <= S_DIV;
                        o_busy  <= 1'b1;
                    end else if (i_op == OP_DIV) begin
                        o_res    <= '1;
                        o_res_hi <= i_lh;
                        o_co     <= i_ci;
                        o_vo     <= 1'b1;
                        o_ho     <= (i_lh[3:0] >= i_r[3:0]);
                        o_so     <= 1'b1;
                        o_zo     <= 1'b0;
                        o_done   <= 1'b1;
                    end else begin
                        o_res    <= w_res;
                        o_res_hi <= '0;
                        o_co     <= w_c;
                        o_vo     <= w_v;
                        o_ho     <= w_h;
                        o_so     <= w_res[W-1];
                        o_zo     <= zero_flag(w_res, i_w16, i_zi);
                        o_done   <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_hi  <= w_mprod[2*W-1:W];
                    r_lo  <= w_mprod[W-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        o_res    <= w_mprod[W-1:0];
                        o_res_hi <= w_mprod[2*W-1:W];
                        o_co     <= r_ci;
                        o_vo     <= r_vi;
                        o_ho     <= r_hf;
                        o_so     <= w_mprod[2*W-1];
                        o_zo     <= zero_flag(w_mprod[2*W-1:W], r_w16, r_zi);
                        o_done   <= 1'b1;
                        o_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_hi  <= w_rem_n;
                    r_lo  <= w_quo_n;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        o_res    <= w_quo_n;
                        o_res_hi <= w_rem_n;
                        o_co     <= r_ci;
                        o_vo     <= 1'b0;
                        o_ho     <= r_hf;
                        o_so     <= w_quo_n[W-1];
                        o_zo     <= zero_flag(w_quo_n, r_w16, r_zi);
                        o_done   <= 1'b1;
                        o_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spc700_alu_seq.sv
// Self-checking bench for spc700_alu_seq (W=8): random ops against an arithmetic reference model plus handshake scenarios.
module tb_spc700_alu_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic [4:0] op = '0;
    logic [7:0] l = '0;
    logic [7:0] lh = '0;
    logic [7:0] r = '0;
    logic       ci = 1'b0;
    logic       hi = 1'b0;
    logic       vi = 1'b0;
    logic       zi = 1'b0;
    logic       w16 = 1'b0;
    logic       o_busy, o_done, o_co, o_vo, o_ho, o_so, o_zo;
    logic [7:0] o_res, o_res_hi;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] res_hi;
        logic c, v, h, s, z;
    } obs_t;

    spc700_alu_seq #(.W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_op(op),
        .i_l(l), .i_lh(lh), .i_r(r), .i_ci(ci), .i_hi(hi), .i_vi(vi), .i_zi(zi), .i_w16(w16),
        .o_busy(o_busy), .o_done(o_done), .o_res(o_res), .o_res_hi(o_res_hi),
        .o_co(o_co), .o_vo(o_vo), .o_ho(o_ho), .o_so(o_so), .o_zo(o_zo)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return {o_res, o_res_hi, o_co, o_vo, o_ho, o_so, o_zo};
    endfunction

    function automatic int sx(input logic [7:0] x);
        return (x > 8'd127) ? int'(x) - 256 : int'(x);
    endfunction

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic obs_t model(input logic [4:0] o, input logic [7:0] a, input logic [7:0] ah,
                                   input logic [7:0] b, input logic c_in, input logic h_in,
                                   input logic v_in, input logic z_in, input logic w);
        int t, t2, cin;
        logic [7:0] fsrc;
        logic bh, bl;
        obs_t e;
        e = '0;
        e.res = a;
        e.c = c_in;
        e.v = v_in;
        e.h = h_in;
        case (o)
            5'h00: e.res = a | b;
            5'h01: e.res = a & b;
            5'h02: e.res = a ^ b;
            5'h03: e.res = b;
            5'h04, 5'h06: begin
                cin = (o == 5'h06) ? 0 : int'(c_in);
                t = int'(a) + int'(b) + cin;
                e.res = t[7:0];
                e.c = (t > 255);
                e.h = ((int'(a) % 16) + (int'(b) % 16) + cin) > 15;
                t2 = sx(a) + sx(b) + cin;
                e.v = (t2 > 127) || (t2 < -128);
            end
            5'h05, 5'h07: begin
                cin = (o == 5'h07) ? 1 : int'(c_in);
                t = int'(a) - int'(b) - (1 - cin);
                e.res = t[7:0];
                e.c = (t >= 0);
                e.h = ((int'(a) % 16) - (int'(b) % 16) - (1 - cin)) >= 0;
                t2 = sx(a) - sx(b) - (1 - cin);
                e.v = (t2 > 127) || (t2 < -128);
            end
            5'h08: begin t = int'(b) * 2; e.res = t[7:0]; e.c = (b >= 8'd128); end
            5'h09: begin t = int'(b) * 2 + int'(c_in); e.res = t[7:0]; e.c = (b >= 8'd128); end
            5'h0A: begin e.res = 8'(int'(b) / 2); e.c = b[0]; end
            5'h0B: begin e.res = 8'(int'(b) / 2 + (c_in ? 128 : 0)); e.c = b[0]; end
            5'h0C: e.res = 8'((int'(b) % 16) * 16 + int'(b) / 16);
            5'h0D: begin t = int'(a) * int'(b); e.res = t[7:0]; e.res_hi = t[15:8]; end
            5'h0E: begin
                e.h = (int'(ah) % 16) >= (int'(b) % 16);
                if (ah >= b) begin
                    e.res = 8'hFF; e.res_hi = ah; e.v = 1'b1;
                end else begin
                    t = int'(ah) * 256 + int'(a);
                    e.res = 8'(t / int'(b)); e.res_hi = 8'(t % int'(b)); e.v = 1'b0;
                end
            end
`ifdef SPC700_ALU_BCD_EN
            5'h10, 5'h11: begin
                bh = c_in || (a > 8'h99);
                bl = h_in || ((int'(a) % 16) > 9);
                if (o == 5'h10) t = int'(a) + (bh ? 96 : 0) + (bl ? 6 : 0);
                else            t = int'(a) - (bh ? 96 : 0) - (bl ? 6 : 0);
                e.res = t[7:0];
                e.c = bh;
            end
`endif
            default: ;
        endcase
        fsrc = (o == 5'h0D) ? e.res_hi : e.res;
        e.s = fsrc[7];
        e.z = (fsrc == 8'h00) && (!w || z_in);
        return e;
    endfunction

    // Issues one op and waits (bounded) for DONE; lat counts clock edges after the accepting edge.
    task automatic run_op(input logic [4:0] o, input logic [7:0] a, input logic [7:0] ah, input logic [7:0] b,
                          input logic c_in, input logic h_in, input logic v_in, input logic z_in, input logic w,
                          input bit disturb, input bit stall, output int lat, output logic busy0, output obs_t got);
        @(negedge clk);
        op = o; l = a; lh = ah; r = b; ci = c_in; hi = h_in; vi = v_in; zi = z_in; w16 = w;
        en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = o_busy;
        lat = 0;
        while (o_done !== 1'b1 && lat < 100) begin
            if (disturb) begin
                op = 5'($urandom); l = 8'($urandom); lh = 8'($urandom); r = 8'($urandom);
                ci = 1'($urandom); zi = 1'($urandom); w16 = 1'($urandom); start = 1'b1;
            end
            en = !(stall && lat >= 2 && lat < 5);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        en = 1'b1;
        got = sample();
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({o_busy, o_done, sample()} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h required=0", {o_busy, o_done, sample()});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        @(posedge clk); #1;
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset done=%b busy=%b required 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_vectors();
        int lat; logic b0; obs_t got, exp;
        run_op(5'h04, 8'h7F, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, b0, got);
        exp = model(5'h04, 8'h7F, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got !== exp || lat != 0 || got.res !== 8'h80 || {got.v, got.s, got.h, got.c} !== 4'b1110) begin
            bad++;
            $display("FAIL adc_7f_01 got=%h lat=%0d required=%h lat=0", got, lat, exp);
        end
        @(posedge clk); #1;
        total++;
        if (o_done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_width done=%b required 0", o_done);
        end
        run_op(5'h07, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, lat, b0, got);
        total++;
        if (got.res !== 8'h00 || got.z !== 1'b0) begin
            bad++;
            $display("FAIL sub_w16_zi0 res=%h zo=%b required res=00 zo=0", got.res, got.z);
        end
        run_op(5'h07, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, lat, b0, got);
        total++;
        if (got.res !== 8'h00 || got.z !== 1'b1 || got.c !== 1'b1) begin
            bad++;
            $display("FAIL sub_w16_zi1 res=%h zo=%b co=%b required res=00 zo=1 co=1", got.res, got.z, got.c);
        end
        run_op(5'h10, 8'h9A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, b0, got);
`ifdef SPC700_ALU_BCD_EN
        total++;
        if (got.res !== 8'h00 || got.c !== 1'b1 || lat != 0) begin
            bad++;
            $display("FAIL daa_9a res=%h co=%b lat=%0d required res=00 co=1 lat=0", got.res, got.c, lat);
        end
`else
        total++;
        if (got.res !== 8'h9A || got.c !== 1'b0 || lat != 0) begin
            bad++;
            $display("FAIL daa_reserved res=%h co=%b lat=%0d required res=9a co=0 lat=0", got.res, got.c, lat);
        end
`endif
    endtask

    task automatic test_single_random();
        int lat; logic b0; obs_t got, exp;
        logic [4:0] o; logic [7:0] a, ah, b; logic c_in, h_in, v_in, z_in, w;
        for (int i = 0; i < 80; i++) begin
            o = 5'($urandom_range(0, 31));
            if (o == 5'h0D || o == 5'h0E) o = 5'h0F;
            a = 8'($urandom); ah = 8'($urandom); b = 8'($urandom);
            c_in = 1'($urandom); h_in = 1'($urandom); v_in = 1'($urandom);
            z_in = 1'($urandom); w = 1'($urandom);
            if (i % 8 == 0) b = a;
            run_op(o, a, ah, b, c_in, h_in, v_in, z_in, w, 1'b0, 1'b0, lat, b0, got);
            exp = model(o, a, ah, b, c_in, h_in, v_in, z_in, w);
            total++;
            if (got !== exp || lat != 0) begin
                bad++;
                $display("FAIL single op=%h l=%h r=%h ci=%b got=%h lat=%0d required=%h lat=0",
                         o, a, b, c_in, got, lat, exp);
            end
        end
    endtask

    task automatic test_mul();
        int lat; logic b0; obs_t got, exp;
        logic [7:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = (i == 0) ? 8'hFF : 8'($urandom);
            b = (i == 0) ? 8'hFF : (i == 1) ? 8'h00 : 8'($urandom);
            run_op(5'h0D, a, 8'h00, b, 1'b0, 1'b0, 1'b0, 1'b1, 1'(i % 2), i > 1, 1'b0, lat, b0, got);
            exp = model(5'h0D, a, 8'h00, b, 1'b0, 1'b0, 1'b0, 1'b1, 1'(i % 2));
            total++;
            if ({got.res_hi, got.res, got.s, got.z} !== {exp.res_hi, exp.res, exp.s, exp.z}
                || lat != 8 || b0 !== 1'b1 || o_busy !== 1'b0) begin
                bad++;
                $display("FAIL mul l=%h r=%h got=%h%h s=%b z=%b lat=%0d busy0=%b required=%h%h s=%b z=%b lat=8 busy0=1",
                         a, b, got.res_hi, got.res, got.s, got.z, lat, b0, exp.res_hi, exp.res, exp.s, exp.z);
            end
        end
        @(posedge clk); #1;
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL start_not_queued done=%b busy=%b required 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_div();
        int lat, elat; logic b0; obs_t got, exp;
        logic [7:0] a, ah, b;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            ah = (i % 4 == 3) ? 8'($urandom) : 8'($urandom_range(0, int'(b)));
            if (i == 0) begin a = 8'h00; ah = 8'h01; b = 8'h10; end
            if (i == 1) begin a = 8'h00; ah = 8'h01; b = 8'h00; end
            run_op(5'h0E, a, ah, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i > 1, 1'b0, lat, b0, got);
            exp = model(5'h0E, a, ah, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            elat = (ah >= b) ? 0 : 8;
            total++;
            if ({got.res, got.res_hi, got.v, got.h, got.s, got.z} !== {exp.res, exp.res_hi, exp.v, exp.h, exp.s, exp.z}
                || lat != elat) begin
                bad++;
                $display("FAIL div lh=%h l=%h r=%h got=%h lat=%0d required=%h lat=%0d",
                         ah, a, b, got, lat, exp, elat);
            end
        end
    endtask

    task automatic test_en_stall();
        int lat; logic b0; obs_t got;
        run_op(5'h0D, 8'hC3, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lat, b0, got);
        total++;
        if (lat != 11 || {got.res_hi, got.res} !== 16'(16'hC3 * 16'h5A)) begin
            bad++;
            $display("FAIL mul_en_stall lat=%0d prod=%h required lat=11 prod=%h", lat, {got.res_hi, got.res},
                     16'(16'hC3 * 16'h5A));
        end
    endtask

    task automatic test_reset_mid_div();
        bit seen = 0;
        @(negedge clk);
        op = 5'h0E; l = 8'h00; lh = 8'h01; r = 8'h10; en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_busy, o_done, sample()} !== '0) begin
            bad++;
            $display("FAIL reset_mid_div got=%h required=0", {o_busy, o_done, sample()});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (o_done === 1'b1) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL no_done_after_abort done seen=1 required 0");
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic b0; obs_t got, exp;
        run_op(5'h06, 8'h12, 8'h00, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, b0, got);
        run_op(5'h0D, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, b0, got);
        total++;
        if (lat != 8 || {got.res_hi, got.res} !== 16'h0100) begin
            bad++;
            $display("FAIL b2b_mul lat=%0d prod=%h required lat=8 prod=0100", lat, {got.res_hi, got.res});
        end
        run_op(5'h02, 8'hF0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lat, b0, got);
        exp = model(5'h02, 8'hF0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (lat != 0 || got !== exp) begin
            bad++;
            $display("FAIL b2b_xor got=%h lat=%0d required=%h lat=0", got, lat, exp);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_single_random();
        test_mul();
        test_div();
        test_en_stall();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
